// File: rtl/switch_pkg.sv
// Shared constants and sizing helper for the slide-switch debouncer.
package switch_pkg;

    localparam int SW_WIDTH        = 8;
    localparam int DEBOUNCE_CYCLES = 1000000;

    // Counter width for a given CNT_MAX; never narrower than one bit.
    function automatic int cnt_width(input int cnt_max);
        if (cnt_max <= 2) begin
            return 1;
        end
        return $clog2(cnt_max);
    endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// One switch bit: synchroniser chain, stability counter and registered stable level.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int CNT_MAX     = DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic accept_o
);

    localparam int          CW       = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   samp;
    logic                   accept;

    assign samp = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (samp == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Held long enough: take the new level and start over.
            stable_d = samp;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign accept_o = accept;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches bit-by-bit and strobes when the clean vector changes.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH       = SW_WIDTH,
    parameter int CNT_MAX     = DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic             changed
);

    logic [WIDTH-1:0] accept;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (switch_raw[i]),
            .stable_o (switch_stable[i]),
            .accept_o (accept[i])
        );
    end

    // Accepts land on the same edge as the stable flops, so the strobe lines up with them.
    assign changed_d = |accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with CNT_MAX=4, SYNC_STAGES=2.
module tb_switch_debouncer;

    logic       clk;
    logic       rst_n;
    logic [7:0] switch_raw;
    logic [7:0] switch_stable;
    logic       changed;

    int n_checks = 0;
    int n_fail   = 0;

    switch_debouncer #(
        .WIDTH       (8),
        .CNT_MAX     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .switch_raw    (switch_raw),
        .switch_stable (switch_stable),
        .changed       (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check(input string tag, input logic [7:0] exp_stable, input logic exp_chg);
        tick();
        check_eq({tag, ".stable"}, {24'h0, switch_stable}, {24'h0, exp_stable});
        check_eq({tag, ".changed"}, {31'h0, changed}, {31'h0, exp_chg});
    endtask

    // Apply a step from the current stable value and check the 6-edge latency.
    task automatic step_and_check(input string tag, input logic [7:0] from, input logic [7:0] to);
        switch_raw = to;
        for (int e = 1; e <= 5; e++) tick_check(tag, from, 1'b0);
        tick_check(tag, to, 1'b1);
        tick_check(tag, to, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        switch_raw = 8'hFF;

        // 1. reset, then release with raw held high
        for (int e = 0; e < 3; e++) tick_check("rst_hold", 8'h00, 1'b0);
        rst_n = 1'b1;
        step_and_check("rst_release", 8'h00, 8'hFF);
        step_and_check("back_to_zero", 8'hFF, 8'h00);

        // 2. clean multi-bit step, single strobe
        step_and_check("clean_9c", 8'h00, 8'h9C);
        step_and_check("clean_back", 8'h9C, 8'h00);

        // 3a. 3-cycle glitch on bit7 is rejected
        switch_raw = 8'h80;
        for (int e = 1; e <= 3; e++) tick_check("glitch3", 8'h00, 1'b0);
        switch_raw = 8'h00;
        for (int e = 4; e <= 12; e++) tick_check("glitch3", 8'h00, 1'b0);

        // 3b. 4-cycle pulse is accepted, then released 6 edges after the falling raw edge
        switch_raw = 8'h80;
        for (int e = 1; e <= 4; e++) tick_check("pulse4", 8'h00, 1'b0);
        switch_raw = 8'h00;
        tick_check("pulse4", 8'h00, 1'b0);
        tick_check("pulse4_rise", 8'h80, 1'b1);
        for (int e = 7; e <= 9; e++) tick_check("pulse4", 8'h80, 1'b0);
        tick_check("pulse4_fall", 8'h00, 1'b1);
        tick_check("pulse4", 8'h00, 1'b0);

        // 4. bouncing bit0, then holds high
        for (int k = 0; k < 10; k++) begin
            switch_raw = (k % 2 == 0) ? 8'h01 : 8'h00;
            tick_check("bounce", 8'h00, 1'b0);
            tick_check("bounce", 8'h00, 1'b0);
        end
        step_and_check("bounce_settle", 8'h00, 8'h01);
        step_and_check("bounce_back", 8'h01, 8'h00);

        // 5. staggered bits, strobe high on two consecutive edges
        switch_raw = 8'h08;
        tick_check("stagger", 8'h00, 1'b0);
        switch_raw = 8'h0C;
        for (int e = 2; e <= 5; e++) tick_check("stagger", 8'h00, 1'b0);
        tick_check("stagger_e6", 8'h08, 1'b1);
        tick_check("stagger_e7", 8'h0C, 1'b1);
        tick_check("stagger_e8", 8'h0C, 1'b0);
        step_and_check("stagger_back", 8'h0C, 8'h00);

        // 6. reset mid-count discards progress
        switch_raw = 8'hF7;
        for (int e = 1; e <= 3; e++) tick_check("midrst", 8'h00, 1'b0);
        rst_n = 1'b0;
        tick_check("midrst_edge", 8'h00, 1'b0);
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) tick_check("midrst_requal", 8'h00, 1'b0);
        tick_check("midrst_accept", 8'hF7, 1'b1);
        tick_check("midrst_after", 8'hF7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw 8 board slide switches before they drive the 4-bit greater-than comparator's switch[7:0] input.
- Each bit is synchronised into clk, then debounced with a per-bit stability counter.
- Outputs a clean, registered switch vector, plus a one-cycle strobe whenever any debounced bit changes.
- The strobe lets downstream logic log or latch comparator results.

Parameters:
- WIDTH, 8: number of switch bits. switch_stable[7:4] and [3:0] map to the comparator's two operands.
- CNT_MAX, 1000000: consecutive clk cycles a synchronised bit must differ from its stable value before it is accepted. The default is 10 ms at 100 MHz. Must be >= 1.
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser. Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- switch_raw  input  WIDTH  asynchronous raw switch levels.
- switch_stable  output  WIDTH  debounced, registered switch vector; feeds the comparator's switch input.
- changed  output  1  one-cycle pulse, high in the same cycle that switch_stable takes a new value.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the clk rising edge.
- Reset (rst_n low at a clk rising edge) clears:
  - all synchroniser flops, switch_stable and changed to 0;
  - every counter to 0.
- Reset mid-count discards all partial counts. After release, the bits re-qualify from zero.
- Synchroniser: per bit, a chain of SYNC_STAGES flops. The last stage is the bit's synchronised sample s[i]. No logic sits between the stages.
- Per-bit debounce state: cnt[i] is $clog2(CNT_MAX) bits wide, minimum 1 bit. Evaluated every rising edge, not in reset:
  - s[i] == switch_stable[i]: cnt[i] <= 0.
  - s[i] != switch_stable[i] and cnt[i] == CNT_MAX-1: switch_stable[i] <= s[i] and cnt[i] <= 0.
  - s[i] != switch_stable[i] otherwise: cnt[i] <= cnt[i] + 1.
- Latency: raw held constant after a change means switch_stable updates on exactly the (SYNC_STAGES + CNT_MAX)-th rising edge after the change. The first capturing edge counts as 1.
- Glitch rejection: any return of s[i] to the stable value before acceptance resets cnt[i]. Pulses shorter than CNT_MAX synchronised cycles never reach switch_stable.
- CNT_MAX = 1: accept after one mismatching sample. The counter never increments.
- The counter never wraps. It saturates by construction at CNT_MAX-1 and is then cleared.
- changed (registered):
  - High for exactly one cycle, coincident with any switch_stable bit updating.
  - If several bits are accepted on the same edge, changed gives a single pulse.
  - Back-to-back accepts on consecutive edges, from different bits, keep changed high in both cycles.
- Bits are fully independent. There is no cross-bit ordering and no shared counter.
- No combinational path from switch_raw to any output.

Decomposition:
- Package switch_pkg:
  - localparam SW_WIDTH = 8;
  - localparam DEBOUNCE_CYCLES = 1000000;
  - a function returning the counter width for a given CNT_MAX.
- One sub-module, debounce_bit:
  - Holds the single-bit synchroniser, counter and stable flop, with parameters CNT_MAX and SYNC_STAGES.
  - Outputs stable and an accept pulse.
- switch_debouncer instantiates WIDTH copies with a generate loop and ORs the accept pulses into the changed flop.

Test Plan (all scenarios use CNT_MAX=4, SYNC_STAGES=2, 10 ns clk):
1. Reset: rst_n=0 for 3 edges with switch_raw=8'hFF -> switch_stable=8'h00 and changed=0 throughout. Release with raw still 8'hFF -> switch_stable=8'hFF on the 6th edge after release, with changed=1 for that one cycle only.
2. Clean step: stable 8'h00, raw -> 8'h9C -> switch_stable=8'h9C exactly 6 edges later. changed pulses once, even though 4 bits changed.
3. Glitch: stable 8'h00, raw bit7 high for 3 cycles then low -> switch_stable stays 8'h00 and changed never asserts. Repeat with a 4-cycle pulse -> bit7 is accepted (8'h80), then returns to 8'h00 six edges after the falling raw edge, with two separate changed pulses.
4. Bouncing input: bit0 toggles every 2 cycles for 20 cycles, then holds 1 -> no change during the toggling. switch_stable[0]=1 six edges after the final transition.
5. Staggered bits: raw bit3 rises at edge 0 and bit2 at edge 1 -> switch_stable goes 8'h08 at edge 6, then 8'h0C at edge 7. changed is high at both edges 6 and 7.
6. Reset mid-count: raw 8'h00 -> 8'hF7. Assert rst_n=0 at edge 4 for 1 cycle, then release -> switch_stable=8'h00 after the reset edge. switch_stable=8'hF7 on the 6th edge after release, not earlier.
